// File: rtl/im_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the IM address
// port and tags each returned word with its word index.
module im_fetch_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int RESET_PC = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    PRIME  = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic              fvalid_q, fvalid_d;
  logic [31:0]       cnt_q, cnt_d;

  logic [ADDR_W-1:0] rpc;
  logic [ADDR_W-1:0] addr;
  logic              hold;
  logic              valid;
  logic              accept;
  logic              unused_rpc_hi;

  assign rpc    = redirect_pc[ADDR_W-1:0];
  assign hold   = stall & fvalid_q;
  assign valid  = fvalid_q & ~redirect_valid;
  assign accept = valid & ~stall;
  assign unused_rpc_hi = &{1'b0, redirect_pc[31:ADDR_W]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= PRIME;
      pc_q     <= RST_PC;
      fpc_q    <= RST_PC;
      fvalid_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      fpc_q    <= fpc_d;
      fvalid_q <= fvalid_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    fpc_d    = fpc_q;
    fvalid_d = fvalid_q;
    cnt_d    = cnt_q + 32'(accept);
    priority case (1'b1)
      redirect_valid: begin
        fpc_d    = rpc;
        pc_d     = rpc + ONE;
        fvalid_d = 1'b1;
        state_d  = RUN;
      end
      halt: begin
        fvalid_d = 1'b0;
        state_d  = HALTED;
      end
      (state_q == HALTED): ;
      (state_q == PRIME): begin
        fpc_d    = pc_q;
        pc_d     = pc_q + ONE;
        fvalid_d = 1'b1;
        state_d  = RUN;
      end
      hold: ;
      default: begin
        fpc_d    = pc_q;
        pc_d     = pc_q + ONE;
        fvalid_d = 1'b1;
      end
    endcase
  end

  // Re-reading fpc_q keeps im_rdata stable while decode is stalled.
  always_comb begin
    addr = pc_q;
    priority case (1'b1)
      redirect_valid:      addr = rpc;
      (state_q == HALTED): addr = fpc_q;
      hold:                addr = fpc_q;
      default:             addr = pc_q;
    endcase
  end

  always_comb begin
    instr       = im_rdata;
    im_addr     = {{(32-ADDR_W){1'b0}}, RST_PC};
    instr_pc    = {{(32-ADDR_W){1'b0}}, fpc_q};
    instr_valid = 1'b0;
    halted      = 1'b0;
    fetch_count = '0;
    if (rst_n) begin
      im_addr     = {{(32-ADDR_W){1'b0}}, addr};
      instr_valid = valid;
      halted      = (state_q == HALTED);
      fetch_count = cnt_q;
    end
  end

endmodule
